// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-wide data-memory initiator.
package mem_pkg;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

   // Sequencer states; busy is high in every state except IDLE.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_LO   = 3'd1,
      RD_HI   = 3'd2,
      RD_WAIT = 3'd3,
      WR_LO   = 3'd4,
      WR_HI   = 3'd5
   } state_e;

   // Access size as carried by req_byte.
   typedef enum logic {
      SIZE_HALF = 1'b0,
      SIZE_BYTE = 1'b1
   } size_e;

   // Widen a loaded byte to a halfword, sign- or zero-extended.
   function automatic logic [HALF_W-1:0] extend_byte(input logic [BYTE_W-1:0] b,
                                                     input logic sgn);
      logic [BYTE_W-1:0] fill;
      fill = (sgn && b[BYTE_W-1]) ? {BYTE_W{1'b1}} : {BYTE_W{1'b0}};
      return {fill, b};
   endfunction

endpackage

// File: rtl/mem_access_master.sv
// Initiator for the byte-wide data memory. Splits a MEM-stage halfword or
// byte load/store into little-endian single-byte cycles (low byte at A, high
// byte at A+1), assembles/extends load data and stalls the pipeline via busy.
// Handshake: a request is taken on the rising edge where req_valid=1 and
// busy=0; requests seen while busy=1 are dropped, not queued. Completion is a
// one-cycle resp_valid pulse, during which the block is already IDLE.
module mem_access_master
   import mem_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              busy,
   output logic              resp_valid,
   output logic [15:0]       resp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [7:0]        mem_rdata
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [HALF_W-1:0]   wdata_q;
   size_e               size_q;
   logic                signed_q;
   logic [BYTE_W-1:0]   lo_q;

   logic                mem_read_d, mem_write_d, resp_valid_d, load_done;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [BYTE_W-1:0]   mem_wdata_d;
   logic [HALF_W-1:0]   load_data;

   assign busy = (state_q != IDLE);

   // State register, latched request fields and registered memory strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= SIZE_HALF;
         signed_q   <= 1'b0;
         lo_q       <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state_q    <= state_d;
         mem_read   <= mem_read_d;
         mem_write  <= mem_write_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         resp_valid <= resp_valid_d;
         if (state_q == IDLE && req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_byte ? SIZE_BYTE : SIZE_HALF;
            signed_q <= req_signed;
         end
         // mem_rdata during RD_HI is the byte read from A.
         if (state_q == RD_HI) lo_q <= mem_rdata;
         if (load_done) resp_rdata <= load_data;
      end
   end

   // Next state plus the memory-side values for the state being entered, so
   // the strobes are registered and line up with the state they belong to.
   always_comb begin
      state_d      = state_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      resp_valid_d = 1'b0;
      load_done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               mem_addr_d = req_addr;
               if (req_write) begin
                  state_d     = WR_LO;
                  mem_write_d = 1'b1;
                  mem_wdata_d = req_wdata[7:0];
               end else begin
                  state_d    = RD_LO;
                  mem_read_d = 1'b1;
               end
            end
         end
         RD_LO: begin
            if (size_q == SIZE_HALF) begin
               state_d    = RD_HI;
               mem_read_d = 1'b1;
               mem_addr_d = addr_q + ADDR_ONE;
            end else begin
               state_d = RD_WAIT;
            end
         end
         RD_HI: state_d = RD_WAIT;
         RD_WAIT: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            load_done    = 1'b1;
         end
         WR_LO: begin
            if (size_q == SIZE_HALF) begin
               state_d     = WR_HI;
               mem_write_d = 1'b1;
               mem_addr_d  = addr_q + ADDR_ONE;
               mem_wdata_d = wdata_q[15:8];
            end else begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
            end
         end
         WR_HI: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Final load value: the byte in mem_rdata during RD_WAIT is the high byte
   // of a halfword, or the only byte of a byte load.
   always_comb begin
      if (size_q == SIZE_HALF) load_data = {mem_rdata, lo_q};
      else                     load_data = extend_byte(mem_rdata, signed_q);
   end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a registered-read byte memory.
module tb_mem_access_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_write, req_byte, req_signed;
   logic [15:0] req_addr, req_wdata;
   logic        busy, resp_valid;
   logic [15:0] resp_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   int total = 0;
   int bad   = 0;
   int both_cnt = 0;

   logic [7:0]  mem [0:65535];
   logic [23:0] wr_log[$];
   logic [15:0] rd_log[$];
   logic [23:0] exp_w[$];
   logic [15:0] exp_r[$];

   mem_access_master #(.ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   // clock
   always #5 clk = ~clk;

   // memory model: write on strobe, read data registered one cycle later
   initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr] <= mem_wdata;
         wr_log.push_back({mem_addr, mem_wdata});
      end
      if (mem_read) begin
         mem_rdata <= mem[mem_addr];
         rd_log.push_back(mem_addr);
      end
   end

   always @(negedge clk) if (mem_read && mem_write) both_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      wr_log.delete(); rd_log.delete(); exp_w.delete(); exp_r.delete();
   endtask

   task automatic check_logs(input string tag);
      chk({tag, "_nwr"}, wr_log.size(), exp_w.size());
      foreach (exp_w[i]) chk({tag, "_wr"}, (i < wr_log.size()) ? wr_log[i] : 24'hxxxxxx, exp_w[i]);
      chk({tag, "_nrd"}, rd_log.size(), exp_r.size());
      foreach (exp_r[i]) chk({tag, "_rd"}, (i < rd_log.size()) ? rd_log[i] : 16'hxxxx, exp_r[i]);
   endtask

   // Drive one request from a point away from the clock edge; returns edges
   // from the accept edge (counted as 1) to the edge raising resp_valid.
   task automatic do_req(input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] wd, input logic poke,
                         output int lat, output int busy_cyc, output logic [15:0] rd);
      chk("idle_before_req", busy, 1'b0);
      req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
      req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; busy_cyc = 0; rd = 16'h0;
      if (poke) begin
         req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
         req_addr = 16'h0050; req_wdata = 16'h00AA;
      end
      for (int i = 0; i < 20; i++) begin
         if (busy) busy_cyc++;
         @(posedge clk); #1;
         req_valid = 1'b0;
         lat++;
         if (resp_valid) begin
            rd = resp_rdata;
            break;
         end
      end
      chk("resp_seen", resp_valid, 1'b1);
   endtask

   int          lat, bcyc, rv_seen;
   logic [15:0] rd;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0); chk("rst_rv", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0); chk("rst_maddr", mem_addr, 0);
      chk("rst_mwdata", mem_wdata, 0); chk("rst_mrd", mem_read, 0);
      chk("rst_mwr", mem_write, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // halfword store 0x0010 <- 0xBEEF
      clear_logs();
      do_req(1, 0, 0, 16'h0010, 16'hBEEF, 0, lat, bcyc, rd);
      chk("hst_lat", lat, 3); chk("hst_busy", bcyc, 2);
      exp_w.push_back({16'h0010, 8'hEF}); exp_w.push_back({16'h0011, 8'hBE});
      check_logs("hst");

      // halfword load back, with a store poked in while busy (must be dropped)
      @(negedge clk); clear_logs();
      do_req(0, 0, 0, 16'h0010, 16'h0000, 1, lat, bcyc, rd);
      chk("hld_lat", lat, 4); chk("hld_data", rd, 16'hBEEF); chk("hld_busy", bcyc, 3);
      exp_r.push_back(16'h0010); exp_r.push_back(16'h0011);
      check_logs("hld");

      // byte loads at 0x0011 (0xBE)
      @(negedge clk); clear_logs();
      do_req(0, 1, 1, 16'h0011, 16'h0000, 0, lat, bcyc, rd);
      chk("bld_s_lat", lat, 3); chk("bld_s_data", rd, 16'hFFBE);
      exp_r.push_back(16'h0011); check_logs("bld_s");
      @(negedge clk);
      do_req(0, 1, 0, 16'h0011, 16'h0000, 0, lat, bcyc, rd);
      chk("bld_u_data", rd, 16'h00BE);

      // byte store 0x1234 at 0x0020: one write, resp_rdata held
      @(negedge clk); clear_logs();
      do_req(1, 1, 1, 16'h0020, 16'h1234, 0, lat, bcyc, rd);
      chk("bst_lat", lat, 2); chk("bst_hold", resp_rdata, 16'h00BE);
      exp_w.push_back({16'h0020, 8'h34}); check_logs("bst");

      // back-to-back: issued during the resp_valid cycle, no idle gap
      do_req(0, 1, 1, 16'h0020, 16'h0000, 0, lat, bcyc, rd);
      chk("b2b_lat", lat, 3); chk("b2b_data", rd, 16'h0034);

      // wrap-around halfword store and load at 0xFFFF
      @(negedge clk); clear_logs();
      do_req(1, 0, 0, 16'hFFFF, 16'hA55A, 0, lat, bcyc, rd);
      chk("wrap_st_lat", lat, 3);
      exp_w.push_back({16'hFFFF, 8'h5A}); exp_w.push_back({16'h0000, 8'hA5});
      check_logs("wrap_st");
      @(negedge clk); clear_logs();
      do_req(0, 0, 1, 16'hFFFF, 16'h0000, 0, lat, bcyc, rd);
      chk("wrap_ld_data", rd, 16'hA55A);
      exp_r.push_back(16'hFFFF); exp_r.push_back(16'h0000); check_logs("wrap_ld");

      // reset in the middle of a halfword load (during RD_HI)
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      chk("mrst_busy", busy, 0); chk("mrst_mrd", mem_read, 0);
      chk("mrst_maddr", mem_addr, 0); chk("mrst_rv", resp_valid, 0);
      chk("mrst_rdata", resp_rdata, 0);
      @(negedge clk); rst_n = 1'b1;
      rv_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid) rv_seen++;
      end
      chk("mrst_no_resp", rv_seen, 0);
      do_req(0, 0, 0, 16'h0010, 16'h0000, 0, lat, bcyc, rd);
      chk("mrst_after_lat", lat, 4); chk("mrst_after_data", rd, 16'hBEEF);

      @(negedge clk);
      chk("poke_ignored", mem[16'h0050], 8'h00);
      chk("rd_wr_excl", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
